// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the transmitter state encoding.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 frame serializer: latches a byte on load and shifts it out LSB first.
// tx and busy are both flops; state is exported for observation.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [UART_DATA_BITS-1:0] load_byte,
    output logic                      tx,
    output logic                      busy,
    output logic                      done,
    output uart_tx_state_e            state
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(UART_DATA_BITS - 1);

    uart_tx_state_e            state_n;
    logic [CW-1:0]             tick, tick_n;
    logic [IW-1:0]             bit_idx, bit_idx_n;
    logic [UART_DATA_BITS-1:0] shreg, shreg_n;
    logic                      tx_n;
    logic                      busy_n;
    logic                      wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tick    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            tick    <= tick_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
            busy    <= busy_n;
        end
    end

    // tx_n is the level of the next bit, so tx changes exactly on bit boundaries.
    always_comb begin
        state_n   = state;
        tick_n    = tick;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        tx_n      = tx;
        done      = 1'b0;
        wrap      = (tick == LAST_TICK);
        case (state)
            IDLE: begin
                tick_n    = '0;
                bit_idx_n = '0;
                tx_n      = 1'b1;
                if (load) begin
                    shreg_n = load_byte;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                tick_n = wrap ? '0 : tick + 1'b1;
                if (wrap) begin
                    tx_n    = shreg[0];
                    state_n = DATA;
                end
            end
            DATA: begin
                tick_n = wrap ? '0 : tick + 1'b1;
                if (wrap) begin
                    if (bit_idx == LAST_BIT) begin
                        bit_idx_n = '0;
                        tx_n      = 1'b1;
                        state_n   = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                        shreg_n   = {1'b0, shreg[UART_DATA_BITS-1:1]};
                        tx_n      = shreg[1];
                    end
                end
            end
            STOP: begin
                tick_n = wrap ? '0 : tick + 1'b1;
                if (wrap) begin
                    tx_n    = 1'b1;
                    done    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Handshake: a byte moves when req_valid[i] & req_ready[i]; ready is only offered while the line is idle.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id
);

    localparam int GW = $clog2(NUM_REQ);

    uart_tx_state_e            ser_state;
    logic [GW-1:0]             last_gnt;
    logic [GW-1:0]             pick;
    logic [GW-1:0]             cand;
    logic                      found;
    logic                      accept;
    logic [UART_DATA_BITS-1:0] sel_byte;
    logic                      unused_done;

    // Search begins one past the previous winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_gnt) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        accept = found && (ser_state == IDLE) && !rst;
    end

    always_comb begin
        req_ready = '0;
        sel_byte  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (pick == GW'(i));
            if (pick == GW'(i)) begin
                sel_byte = req_data[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_id   <= '0;
            last_gnt <= GW'(NUM_REQ - 1);
        end else if (accept) begin
            gnt_id   <= pick;
            last_gnt <= pick;
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serializer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_byte(sel_byte),
        .tx       (tx),
        .busy     (busy),
        .done     (unused_done),
        .state    (ser_state)
    );

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a frame-level reference model predicts tx, busy, ready and gnt_id every cycle.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic            clk = 1'b0;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            tx;
  logic            busy;
  logic [1:0]      gnt_id;

  int total = 0;
  int bad = 0;
  int cyc_no = 0;

  // reference model: cycles left in the current frame, its byte, round-robin pointer
  int         m_left = 0;
  int         m_last = NREQ - 1;
  int         m_gnt = 0;
  logic [7:0] m_byte = 8'h00;

  logic            exp_tx, exp_busy, obs_tx, obs_busy;
  logic [NREQ-1:0] exp_ready, obs_ready;
  logic [1:0]      exp_gnt, obs_gnt;
  int              acc_q[$];
  int              acc_cyc_q[$];
  logic            tx_q[$];
  logic [1:0]      exp_q[$];

  uart_tx_arbiter #(.NUM_REQ(NREQ), .CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .tx       (tx),
    .busy     (busy),
    .gnt_id   (gnt_id)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc_no);
    $fatal(1, "watchdog");
  end

  task automatic set_byte(input int i, input logic [7:0] b);
    req_data[i*8 +: 8] = b;
  endtask

  // One clock: predict this cycle's outputs, sample the DUT at negedge, advance the model.
  task automatic step();
    logic [9:0] frame;
    int pick;
    @(negedge clk);
    if (m_left > 0) begin
      frame    = {1'b1, m_byte, 1'b0};
      exp_tx   = frame[(FRAME - m_left) / CPB];
      exp_busy = 1'b1;
    end else begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end
    exp_gnt   = 2'(m_gnt);
    exp_ready = '0;
    pick      = -1;
    if (m_left == 0 && !rst) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (pick < 0 && req_valid[(m_last + k) % NREQ]) pick = (m_last + k) % NREQ;
      end
    end
    if (pick >= 0) exp_ready[pick] = 1'b1;
    obs_tx    = tx;
    obs_busy  = busy;
    obs_ready = req_ready;
    obs_gnt   = gnt_id;
    for (int i = 0; i < NREQ; i++) begin
      if (obs_ready[i] === 1'b1) begin
        acc_q.push_back(i);
        acc_cyc_q.push_back(cyc_no);
      end
    end
    tx_q.push_back(obs_tx);
    if (rst) begin
      m_left = 0;
      m_gnt  = 0;
      m_last = NREQ - 1;
    end else if (m_left > 0) begin
      m_left--;
    end else if (pick >= 0) begin
      m_left = FRAME;
      m_byte = req_data[pick*8 +: 8];
      m_gnt  = pick;
      m_last = pick;
    end
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step();
      total += 4;
      if (obs_ready !== exp_ready) begin bad++; $display("FAIL reset_ready cyc=%0d got=%b want=%b", cyc_no, obs_ready, exp_ready); end
      if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL reset_gnt cyc=%0d got=%0d want=%0d", cyc_no, obs_gnt, exp_gnt); end
      if (obs_tx !== exp_tx) begin bad++; $display("FAIL reset_tx cyc=%0d got=%b want=%b", cyc_no, obs_tx, exp_tx); end
      if (obs_busy !== exp_busy) begin bad++; $display("FAIL reset_busy cyc=%0d got=%b want=%b", cyc_no, obs_busy, exp_busy); end
      total++;
      if (obs_tx !== 1'b1 || obs_busy !== 1'b0 || obs_ready !== 4'b0000 || obs_gnt !== 2'd0) begin
        bad++; $display("FAIL reset_values tx=%b busy=%b ready=%b gnt=%0d want 1 0 0000 0", obs_tx, obs_busy, obs_ready, obs_gnt);
      end
    end
    req_valid = '0;
  endtask

  task automatic test_single_a5();
    logic [9:0] pat;
    int busy_cnt;
    int bit_err;
    pat = 10'b11_0100_1010;
    busy_cnt = 0;
    acc_q.delete();
    rst = 1'b0;
    req_valid = 4'b0001;
    set_byte(0, 8'hA5);
    step();
    total += 4;
    if (obs_ready !== exp_ready) begin bad++; $display("FAIL a5_ready cyc=%0d got=%b want=%b", cyc_no, obs_ready, exp_ready); end
    if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL a5_gnt cyc=%0d got=%0d want=%0d", cyc_no, obs_gnt, exp_gnt); end
    if (obs_tx !== exp_tx) begin bad++; $display("FAIL a5_tx cyc=%0d got=%b want=%b", cyc_no, obs_tx, exp_tx); end
    if (obs_busy !== exp_busy) begin bad++; $display("FAIL a5_busy cyc=%0d got=%b want=%b", cyc_no, obs_busy, exp_busy); end
    total++;
    if (obs_ready !== 4'b0001) begin bad++; $display("FAIL a5_first_accept got=%b want=0001", obs_ready); end
    req_valid = '0;
    tx_q.delete();
    for (int c = 0; c < 42; c++) begin
      step();
      total += 4;
      if (obs_ready !== exp_ready) begin bad++; $display("FAIL a5_ready cyc=%0d got=%b want=%b", cyc_no, obs_ready, exp_ready); end
      if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL a5_gnt cyc=%0d got=%0d want=%0d", cyc_no, obs_gnt, exp_gnt); end
      if (obs_tx !== exp_tx) begin bad++; $display("FAIL a5_tx cyc=%0d got=%b want=%b", cyc_no, obs_tx, exp_tx); end
      if (obs_busy !== exp_busy) begin bad++; $display("FAIL a5_busy cyc=%0d got=%b want=%b", cyc_no, obs_busy, exp_busy); end
      if (obs_busy === 1'b1) busy_cnt++;
    end
    for (int b = 0; b < 10; b++) begin
      bit_err = 0;
      for (int s = 0; s < CPB; s++) if (tx_q[b*CPB + s] !== pat[b]) bit_err++;
      total++;
      if (bit_err != 0) begin bad++; $display("FAIL a5_wave bit=%0d wrong_samples=%0d want_level=%b", b, bit_err, pat[b]); end
    end
    total += 2;
    if (tx_q[40] !== 1'b1) begin bad++; $display("FAIL a5_idle_after got=%b want=1", tx_q[40]); end
    if (busy_cnt != 40) begin bad++; $display("FAIL a5_busy_len got=%0d want=40", busy_cnt); end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    step();
    total += 4;
    if (obs_ready !== exp_ready) begin bad++; $display("FAIL rr_ready cyc=%0d got=%b want=%b", cyc_no, obs_ready, exp_ready); end
    if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL rr_gnt cyc=%0d got=%0d want=%0d", cyc_no, obs_gnt, exp_gnt); end
    if (obs_tx !== exp_tx) begin bad++; $display("FAIL rr_tx cyc=%0d got=%b want=%b", cyc_no, obs_tx, exp_tx); end
    if (obs_busy !== exp_busy) begin bad++; $display("FAIL rr_busy cyc=%0d got=%b want=%b", cyc_no, obs_busy, exp_busy); end
    rst = 1'b0;
    acc_q.delete();
    acc_cyc_q.delete();
    for (int i = 0; i < NREQ; i++) set_byte(i, 8'($urandom));
    req_valid = 4'b1111;
    for (int c = 0; c < 300; c++) begin
      step();
      total += 4;
      if (obs_ready !== exp_ready) begin bad++; $display("FAIL rr_ready cyc=%0d got=%b want=%b", cyc_no, obs_ready, exp_ready); end
      if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL rr_gnt cyc=%0d got=%0d want=%0d", cyc_no, obs_gnt, exp_gnt); end
      if (obs_tx !== exp_tx) begin bad++; $display("FAIL rr_tx cyc=%0d got=%b want=%b", cyc_no, obs_tx, exp_tx); end
      if (obs_busy !== exp_busy) begin bad++; $display("FAIL rr_busy cyc=%0d got=%b want=%b", cyc_no, obs_busy, exp_busy); end
      for (int i = 0; i < NREQ; i++) if (obs_ready[i] === 1'b1) set_byte(i, 8'($urandom));
      if (acc_q.size() >= 5) begin
        req_valid = '0;
        break;
      end
    end
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    total++;
    if (acc_q.size() != exp_q.size()) begin bad++; $display("FAIL rr_count got=%0d want=%0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= acc_q.size() || acc_q[i] != int'(exp_q[i])) begin
        bad++; $display("FAIL rr_order idx=%0d got=%0d want=%0d", i, (i < acc_q.size()) ? acc_q[i] : -1, exp_q[i]);
      end
    end
    for (int i = 0; i + 1 < acc_cyc_q.size(); i++) begin
      total++;
      if (acc_cyc_q[i+1] - acc_cyc_q[i] != FRAME + 1) begin
        bad++; $display("FAIL rr_spacing idx=%0d got=%0d want=%0d", i, acc_cyc_q[i+1] - acc_cyc_q[i], FRAME + 1);
      end
    end
  endtask

  task automatic test_skip_pair();
    int seen02;
    seen02 = 0;
    acc_q.delete();
    req_valid = 4'b1000;
    for (int c = 0; c < 400; c++) begin
      step();
      total += 4;
      if (obs_ready !== exp_ready) begin bad++; $display("FAIL pair_ready cyc=%0d got=%b want=%b", cyc_no, obs_ready, exp_ready); end
      if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL pair_gnt cyc=%0d got=%0d want=%0d", cyc_no, obs_gnt, exp_gnt); end
      if (obs_tx !== exp_tx) begin bad++; $display("FAIL pair_tx cyc=%0d got=%b want=%b", cyc_no, obs_tx, exp_tx); end
      if (obs_busy !== exp_busy) begin bad++; $display("FAIL pair_busy cyc=%0d got=%b want=%b", cyc_no, obs_busy, exp_busy); end
      if (obs_ready[0] !== 1'b0 || obs_ready[2] !== 1'b0) seen02++;
      if (acc_q.size() == 1) req_valid = 4'b1010;
      for (int i = 0; i < NREQ; i++) if (obs_ready[i] === 1'b1) set_byte(i, 8'($urandom));
      if (acc_q.size() >= 4) begin
        req_valid = '0;
        break;
      end
    end
    exp_q = '{2'd3, 2'd1, 2'd3, 2'd1};
    total += 2;
    if (seen02 != 0) begin bad++; $display("FAIL pair_no_ready02 got=%0d want=0", seen02); end
    if (acc_q.size() != exp_q.size()) begin bad++; $display("FAIL pair_count got=%0d want=%0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= acc_q.size() || acc_q[i] != int'(exp_q[i])) begin
        bad++; $display("FAIL pair_order idx=%0d got=%0d want=%0d", i, (i < acc_q.size()) ? acc_q[i] : -1, exp_q[i]);
      end
    end
  endtask

  task automatic test_data_hold();
    logic [7:0] got;
    int phase;
    int k;
    phase = 0;
    k = 0;
    got = '0;
    req_valid = 4'b0001;
    set_byte(0, 8'h3C);
    for (int c = 0; c < 300; c++) begin
      step();
      total += 4;
      if (obs_ready !== exp_ready) begin bad++; $display("FAIL hold_ready cyc=%0d got=%b want=%b", cyc_no, obs_ready, exp_ready); end
      if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL hold_gnt cyc=%0d got=%0d want=%0d", cyc_no, obs_gnt, exp_gnt); end
      if (obs_tx !== exp_tx) begin bad++; $display("FAIL hold_tx cyc=%0d got=%b want=%b", cyc_no, obs_tx, exp_tx); end
      if (obs_busy !== exp_busy) begin bad++; $display("FAIL hold_busy cyc=%0d got=%b want=%b", cyc_no, obs_busy, exp_busy); end
      if (phase == 0 && obs_ready[0] === 1'b1) begin
        req_valid = '0;
        set_byte(0, 8'hFF);
        tx_q.delete();
        phase = 1;
      end else if (phase == 1) begin
        k++;
        if (k >= 42) break;
      end
    end
    for (int j = 0; j < 8; j++) got[j] = (tx_q.size() > CPB*(1+j) + 2) ? tx_q[CPB*(1+j) + 2] : 1'bx;
    total++;
    if (got !== 8'h3C) begin bad++; $display("FAIL hold_byte got=%h want=3c", got); end
  endtask

  task automatic test_reset_mid();
    int phase;
    int k;
    phase = 0;
    k = 0;
    req_valid = 4'b0100;
    set_byte(2, 8'($urandom));
    set_byte(0, 8'($urandom));
    for (int c = 0; c < 300; c++) begin
      step();
      total += 4;
      if (obs_ready !== exp_ready) begin bad++; $display("FAIL abort_ready cyc=%0d got=%b want=%b", cyc_no, obs_ready, exp_ready); end
      if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL abort_gnt cyc=%0d got=%0d want=%0d", cyc_no, obs_gnt, exp_gnt); end
      if (obs_tx !== exp_tx) begin bad++; $display("FAIL abort_tx cyc=%0d got=%b want=%b", cyc_no, obs_tx, exp_tx); end
      if (obs_busy !== exp_busy) begin bad++; $display("FAIL abort_busy cyc=%0d got=%b want=%b", cyc_no, obs_busy, exp_busy); end
      case (phase)
        0: if (obs_ready[2] === 1'b1) begin req_valid = '0; phase = 1; k = 0; end
        1: begin
          k++;
          // 17 cycles after the accept the line is inside data bit 3
          if (k == 17) begin rst = 1'b1; req_valid = 4'b0101; phase = 2; end
        end
        2: begin
          total++;
          if (obs_ready !== 4'b0000) begin bad++; $display("FAIL abort_ready_in_rst got=%b want=0000", obs_ready); end
          rst = 1'b0;
          phase = 3;
        end
        3: begin
          total += 3;
          if (obs_tx !== 1'b1) begin bad++; $display("FAIL abort_tx_after got=%b want=1", obs_tx); end
          if (obs_busy !== 1'b0) begin bad++; $display("FAIL abort_busy_after got=%b want=0", obs_busy); end
          if (obs_ready !== 4'b0001) begin bad++; $display("FAIL abort_next_grant got=%b want=0001", obs_ready); end
          req_valid = '0;
          phase = 4;
          k = 0;
        end
        default: begin
          k++;
          if (k >= 45) break;
        end
      endcase
    end
  endtask

  task automatic test_drop_valid();
    int phase;
    int k;
    int seen2;
    phase = 0;
    k = 0;
    seen2 = 0;
    acc_q.delete();
    req_valid = 4'b0010;
    for (int i = 0; i < NREQ; i++) set_byte(i, 8'($urandom));
    for (int c = 0; c < 300; c++) begin
      step();
      total += 4;
      if (obs_ready !== exp_ready) begin bad++; $display("FAIL drop_ready cyc=%0d got=%b want=%b", cyc_no, obs_ready, exp_ready); end
      if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL drop_gnt cyc=%0d got=%0d want=%0d", cyc_no, obs_gnt, exp_gnt); end
      if (obs_tx !== exp_tx) begin bad++; $display("FAIL drop_tx cyc=%0d got=%b want=%b", cyc_no, obs_tx, exp_tx); end
      if (obs_busy !== exp_busy) begin bad++; $display("FAIL drop_busy cyc=%0d got=%b want=%b", cyc_no, obs_busy, exp_busy); end
      if (obs_ready[2] !== 1'b0) seen2++;
      if (phase == 0 && acc_q.size() == 1) begin
        req_valid = 4'b0100;
        phase = 1;
      end else if (phase == 1) begin
        k++;
        if (k == 10) begin req_valid = 4'b1000; phase = 2; end
      end else if (phase == 2 && acc_q.size() >= 2) begin
        req_valid = '0;
        break;
      end
    end
    exp_q = '{2'd1, 2'd3};
    total += 2;
    if (seen2 != 0) begin bad++; $display("FAIL drop_no_ready2 got=%0d want=0", seen2); end
    if (acc_q.size() != exp_q.size()) begin bad++; $display("FAIL drop_count got=%0d want=%0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= acc_q.size() || acc_q[i] != int'(exp_q[i])) begin
        bad++; $display("FAIL drop_order idx=%0d got=%0d want=%0d", i, (i < acc_q.size()) ? acc_q[i] : -1, exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 7) == 0) req_valid = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 399) == 0);
      step();
      total += 4;
      if (obs_ready !== exp_ready) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc_no, obs_ready, exp_ready); end
      if (obs_gnt !== exp_gnt) begin bad++; $display("FAIL rand_gnt cyc=%0d got=%0d want=%0d", cyc_no, obs_gnt, exp_gnt); end
      if (obs_tx !== exp_tx) begin bad++; $display("FAIL rand_tx cyc=%0d got=%b want=%b", cyc_no, obs_tx, exp_tx); end
      if (obs_busy !== exp_busy) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b want=%b", cyc_no, obs_busy, exp_busy); end
      for (int i = 0; i < NREQ; i++) if (obs_ready[i] === 1'b1) set_byte(i, 8'($urandom));
    end
    rst = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_round_robin();
    test_skip_pair();
    test_data_hold();
    test_reset_mid();
    test_drop_valid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
